// File: rtl/sram_rd_bridge_if.sv
// Cache-side word read handshake: four-phase valid/ready with a 17-bit byte address.
interface sram_rd_bridge_if;
   logic [16:0] sys_addr;
   logic        sys_valid;
   logic        sys_ready;
   logic [31:0] sys_rdata;

   modport master (
      output sys_addr,
      output sys_valid,
      input  sys_ready,
      input  sys_rdata
   );

   modport slave (
      input  sys_addr,
      input  sys_valid,
      output sys_ready,
      output sys_rdata
   );
endinterface

// File: rtl/sram_rd_bridge.sv
// Read-only bridge from the cache word port to a 16-bit async SRAM: two halfword reads with a
// programmable access time, assembled little-endian into one 32-bit word.
module sram_rd_bridge #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   sram_rd_bridge_if.slave        bus,
   output logic [15:0]            o_sram_addr,
   input  logic [15:0]            i_sram_dq,
   output logic                   o_sram_ce_n,
   output logic                   o_sram_oe_n,
   output logic                   o_sram_lb_n,
   output logic                   o_sram_ub_n
);

   localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StRdLo, StRdHi, StDone} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [14:0] r_word;
   logic [15:0] r_lo;
   logic [31:0] r_rdata;
   logic        r_ready;
   logic [15:0] r_sram_addr;
   logic        r_en_n;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_word      <= 15'd0;
         r_lo        <= 16'd0;
         r_rdata     <= 32'd0;
         r_ready     <= 1'b0;
         r_sram_addr <= 16'd0;
         r_en_n      <= 1'b1;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (bus.sys_valid && !r_ready) begin
                  r_word      <= bus.sys_addr[16:2];
                  r_sram_addr <= {bus.sys_addr[16:2], 1'b0};
                  r_en_n      <= 1'b0;
                  r_cnt       <= RELOAD;
                  r_state     <= StRdLo;
               end
            end
            StRdLo: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_lo        <= i_sram_dq;
                  r_sram_addr <= {r_word, 1'b1};
                  r_cnt       <= RELOAD;
                  r_state     <= StRdHi;
               end
            end
            StRdHi: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rdata <= {i_sram_dq, r_lo};
                  r_ready <= 1'b1;
                  r_en_n  <= 1'b1;
                  r_state <= StDone;
               end
            end
            StDone: begin
               // Returning to idle without accepting guarantees the cache sees ready low first.
               if (!bus.sys_valid) begin
                  r_ready <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.sys_ready = r_ready;
   assign bus.sys_rdata = r_rdata;
   assign o_sram_addr   = r_sram_addr;
   assign o_sram_ce_n   = r_en_n;
   assign o_sram_oe_n   = r_en_n;
   assign o_sram_lb_n   = r_en_n;
   assign o_sram_ub_n   = r_en_n;

endmodule

// File: tb/tb_sram_rd_bridge.sv
// Bench for sram_rd_bridge: two instances (WAIT_CYCLES=2 and 1) sharing one SRAM image.
module tb_sram_rd_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_rd_bridge_if ifa ();
   sram_rd_bridge_if ifb ();

   logic [15:0] sa_addr, sb_addr, dqa, dqb;
   logic        cea, oea, lba, uba, ceb, oeb, lbb, ubb;
   logic [15:0] mem [65536];

   // SRAM only drives valid data while fully enabled.
   assign dqa = (!cea && !oea && !lba && !uba) ? mem[sa_addr] : 16'hDEAD;
   assign dqb = (!ceb && !oeb && !lbb && !ubb) ? mem[sb_addr] : 16'hDEAD;

   sram_rd_bridge #(.WAIT_CYCLES(2)) u_dut_a (
      .i_clk       (clk),
      .i_rst       (rst),
      .bus         (ifa.slave),
      .o_sram_addr (sa_addr),
      .i_sram_dq   (dqa),
      .o_sram_ce_n (cea),
      .o_sram_oe_n (oea),
      .o_sram_lb_n (lba),
      .o_sram_ub_n (uba)
   );

   sram_rd_bridge #(.WAIT_CYCLES(1)) u_dut_b (
      .i_clk       (clk),
      .i_rst       (rst),
      .bus         (ifb.slave),
      .o_sram_addr (sb_addr),
      .i_sram_dq   (dqb),
      .o_sram_ce_n (ceb),
      .o_sram_oe_n (oeb),
      .o_sram_lb_n (lbb),
      .o_sram_ub_n (ubb)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [16:0] addr;
      int          hold;
      logic [31:0] exp_rdata;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int sel, input logic v, input logic [16:0] a);
      if (sel == 0) begin
         ifa.sys_valid = v;
         ifa.sys_addr  = a;
      end else begin
         ifb.sys_valid = v;
         ifb.sys_addr  = a;
      end
   endtask

   function automatic logic g_ready(input int sel);
      return (sel == 0) ? ifa.sys_ready : ifb.sys_ready;
   endfunction

   function automatic logic [31:0] g_rdata(input int sel);
      return (sel == 0) ? ifa.sys_rdata : ifb.sys_rdata;
   endfunction

   function automatic logic [15:0] g_saddr(input int sel);
      return (sel == 0) ? sa_addr : sb_addr;
   endfunction

   function automatic logic [3:0] g_en(input int sel);
      return (sel == 0) ? {cea, oea, lba, uba} : {ceb, oeb, lbb, ubb};
   endfunction

   // Called at posedge+1; issues a request, checks timing, holds, releases.
   task automatic run_txn(input int sel, input logic [16:0] addr, input int hold,
                          input bit change_addr, input logic [31:0] exp_rdata);
      int          w;
      int          lat;
      int          en_cnt;
      bit          addr_ok;
      bit          en_ok;
      logic [15:0] lo_a, hi_a, exp_lo, exp_hi;
      logic [31:0] rd;
      w       = (sel == 0) ? 2 : 1;
      lat     = -1;
      en_cnt  = 0;
      addr_ok = 1'b1;
      en_ok   = 1'b1;
      lo_a    = 16'h0;
      hi_a    = 16'h0;
      exp_lo  = 16'((int'(addr) / 4) * 2);
      exp_hi  = exp_lo + 16'd1;
      set_req(sel, 1'b1, addr);
      for (int k = 0; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            lo_a = g_saddr(sel);
            if (change_addr) set_req(sel, 1'b1, 17'h00200);
         end
         if (k == w) hi_a = g_saddr(sel);
         if (k > 0 && k < w && g_saddr(sel) !== lo_a) addr_ok = 1'b0;
         if (k > w && g_saddr(sel) !== hi_a) addr_ok = 1'b0;
         if (g_en(sel) == 4'b0000) en_cnt++;
         else if (g_en(sel) != 4'b1111) en_ok = 1'b0;
         if (g_ready(sel)) begin
            lat = k;
            break;
         end
      end
      chk("latency", 32'(lat), 32'(2 * w));
      chk("enable_cycles", 32'(en_cnt), 32'(2 * w));
      chk("enable_coherent", 32'(en_ok), 32'd1);
      chk("addr_lo", 32'(lo_a), 32'(exp_lo));
      chk("addr_hi", 32'(hi_a), 32'(exp_hi));
      chk("addr_stable", 32'(addr_ok), 32'd1);
      chk("rdata", g_rdata(sel), exp_rdata);
      rd = g_rdata(sel);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("ready_hold", 32'(g_ready(sel)), 32'd1);
         chk("rdata_hold", g_rdata(sel), rd);
      end
      set_req(sel, 1'b0, addr);
      @(posedge clk);
      #1;
      chk("ready_release", 32'(g_ready(sel)), 32'd0);
      chk("idle_at_release", 32'(g_en(sel)), 32'hF);
   endtask

   task automatic chk_reset_state(input int sel);
      chk("rst_ready", 32'(g_ready(sel)), 32'd0);
      chk("rst_rdata", g_rdata(sel), 32'd0);
      chk("rst_sram_addr", 32'(g_saddr(sel)), 32'd0);
      chk("rst_enables", 32'(g_en(sel)), 32'hF);
   endtask

   vec_t vecs [6];

   initial begin
      int          saw_ready;
      int          sel, idle, hold;
      logic [16:0] a;
      int          lo_idx;
      logic [31:0] exp;

      // Identity image: each halfword holds its own address.
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i);

      vecs[0] = '{17'h00104, 3, 32'h00830082};
      vecs[1] = '{17'h00000, 0, 32'h00010000};
      vecs[2] = '{17'h1FFFC, 1, 32'hFFFFFFFE};
      vecs[3] = '{17'h0ABCD, 2, 32'h55E755E6};
      vecs[4] = '{17'h10003, 0, 32'h80018000};
      vecs[5] = '{17'h00006, 1, 32'h00030002};

      set_req(0, 1'b0, 17'h0);
      set_req(1, 1'b0, 17'h0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk_reset_state(0);
      chk_reset_state(1);

      // Back-to-back: each request is raised right after the previous release edge.
      foreach (vecs[i]) run_txn(0, vecs[i].addr, vecs[i].hold, 1'b0, vecs[i].exp_rdata);

      run_txn(1, 17'h1FFFF, 3, 1'b0, 32'hFFFFFFFE);

      repeat (2) @(posedge clk);
      #1;
      run_txn(0, 17'h00104, 0, 1'b1, 32'h00830082);

      repeat (5) @(posedge clk);
      #1;
      chk("rdata_idle_hold", ifa.sys_rdata, 32'h00830082);

      // Reset during the high-half read abandons the transaction.
      set_req(0, 1'b1, 17'h00104);
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("in_rd_hi_addr", 32'(sa_addr), 32'h0083);
      rst = 1'b1;
      set_req(0, 1'b0, 17'h00104);
      @(posedge clk);
      #1;
      chk_reset_state(0);
      rst = 1'b0;
      saw_ready = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (ifa.sys_ready) saw_ready++;
      end
      chk("no_ready_after_reset", 32'(saw_ready), 32'd0);
      run_txn(0, 17'h0ABCD, 1, 1'b0, 32'h55E755E6);

      // Randomized image and traffic against the word-assembly model.
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      for (int n = 0; n < 40; n++) begin
         sel    = int'($urandom_range(0, 1));
         a      = 17'($urandom);
         idle   = int'($urandom_range(0, 2));
         hold   = int'($urandom_range(0, 3));
         lo_idx = (int'(a) / 4) * 2;
         exp    = {mem[lo_idx + 1], mem[lo_idx]};
         repeat (idle) begin
            @(posedge clk);
            #1;
         end
         run_txn(sel, a, hold, ($urandom_range(0, 3) == 0), exp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
